hazard_control_unit: RTL

Feedback controller for the 5-stage ARM pipeline. It watches the destination and control fields carried downstream by the ID/EX, EX/MEM and MEM/WB registers, compares them with the ID-stage source registers, and drives the upstream enables: PC enable, IF/ID enable and flush, and the CU-mux NOP select. It also produces operand forwarding selects and counts stall and flush events.

---
 rtl/hazard_control_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall, branch flush, operand forwarding and event counters for the 5-stage pipeline
module hazard_control_unit #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           id_rn,
    input  logic [3:0]           id_rm,
    input  logic [3:0]           id_rd_src,
    input  logic                 id_use_rn,
    input  logic                 id_use_rm,
    input  logic                 id_use_rd,
    input  logic                 id_branch_taken,
    input  logic [3:0]           ex_rd,
    input  logic                 ex_reg_write,
    input  logic                 ex_mem_to_reg,
    input  logic [3:0]           mem_rd,
    input  logic                 mem_reg_write,
    input  logic [3:0]           wb_rd,
    input  logic                 wb_reg_write,
    output logic                 pc_enable,
    output logic                 if_id_enable,
    output logic                 if_id_flush,
    output logic                 cu_mux_select,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [1:0]           fwd_c,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t     state, state_nx;
    logic [2:0] flush_left, flush_left_nx;
    logic       luh;
    function automatic logic [1:0] fwd_sel(input logic [3:0] s, input logic u);
        return (!u || s == 4'd15) ? 2'b00 :
               (ex_reg_write && !ex_mem_to_reg && s == ex_rd) ? 2'b01 :
               (mem_reg_write && s == mem_rd) ? 2'b10 :
               (wb_reg_write && s == wb_rd) ? 2'b11 : 2'b00;
    endfunction
    assign luh = ex_reg_write && ex_mem_to_reg && ex_rd != 4'd15 &&
                 ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd) ||
                  (id_use_rd && id_rd_src == ex_rd));
    always_comb begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        if_id_flush   = 1'b0;
        cu_mux_select = 1'b0;
        state_nx      = state;
        flush_left_nx = flush_left;
        fwd_a         = reset ? 2'b00 : fwd_sel(id_rn, id_use_rn);
        fwd_b         = reset ? 2'b00 : fwd_sel(id_rm, id_use_rm);
        fwd_c         = reset ? 2'b00 : fwd_sel(id_rd_src, id_use_rd);
        if (reset) begin
            state_nx      = RUN;
            flush_left_nx = 3'd0;
        end else if (state == FLUSH) begin
            if_id_flush   = 1'b1;
            cu_mux_select = 1'b1;
            flush_left_nx = (flush_left == 3'd0) ? 3'd0 : flush_left - 3'd1;
            state_nx      = (flush_left <= 3'd1) ? RUN : FLUSH;
        end else if (luh) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            cu_mux_select = 1'b1;
        end else if (id_branch_taken) begin
            if_id_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nx      = FLUSH;
                flush_left_nx = 3'(FLUSH_CYCLES - 1);
            end
        end
    end
    // stalls are counted only when RUN actually honours the hazard
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            flush_left  <= 3'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state      <= state_nx;
            flush_left <= flush_left_nx;
            if (state == RUN && luh && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (if_id_flush && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end
endmodule
